// File: rtl/commit_trace_unit_pkg.sv
// Shared types for the commit trace unit: core-wide XLEN/exception codes plus
// trace record, halt cause and FSM state definitions.
package commit_trace_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    NO_ERROR             = 4'd0,
    INST_ACCESS_FAULT    = 4'd1,
    ILLEGAL_INST         = 4'd2,
    BREAKPOINT           = 4'd3,
    LOAD_ADDR_MISALIGNED = 4'd4,
    LOAD_ACCESS_FAULT    = 4'd5,
    STORE_ACCESS_FAULT   = 4'd7,
    ECALL                = 4'd8
  } exception_code_t;

  typedef enum logic [1:0] {
    HaltNone,
    HaltError,
    HaltWatchdog
  } halt_cause_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      arn;
    logic [XLEN-1:0] data;
  } trace_rec_t;

  // Load access faults are expected during normal runs and must not stop the trace.
  function automatic logic is_fatal_error(exception_code_t code);
    return (code != NO_ERROR) && (code != LOAD_ACCESS_FAULT);
  endfunction

endpackage

// File: rtl/commit_trace_unit_fifo.sv
// Trace FIFO: compacting multi-lane push, single pop, head read straight from storage.
module trace_fifo
  import commit_trace_unit_pkg::*;
#(
  parameter int unsigned WAYS  = 3,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_en,
  input  logic [WAYS-1:0]            push_valid,
  input  trace_rec_t                 push_rec [WAYS],
  input  logic                       pop_req,
  output trace_rec_t                 head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] count_next,
  output logic [$clog2(DEPTH+1)-1:0] drop_n
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH+1);

  trace_rec_t      mem [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] free;
  logic [CntW-1:0] n_push;
  logic [WAYS-1:0] lane_acc;
  logic [PtrW-1:0] lane_idx [WAYS];
  logic            pop;

  // Free space ignores a same-cycle pop, so lanes beyond it are dropped.
  always_comb begin
    free   = CntW'(DEPTH) - count_q;
    n_push = '0;
    drop_n = '0;
    for (int i = 0; i < WAYS; i++) begin
      lane_idx[i] = wptr_q + PtrW'(n_push);
      lane_acc[i] = 1'b0;
      if (push_en && push_valid[i]) begin
        if (n_push < free) begin
          lane_acc[i] = 1'b1;
          n_push      = n_push + CntW'(1);
        end else begin
          drop_n = drop_n + CntW'(1);
        end
      end
    end
  end

  assign pop        = pop_req && (count_q != '0);
  assign count_next = count_q + n_push - CntW'(pop);
  assign count      = count_q;
  assign head       = mem[rptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + PtrW'(n_push);
      rptr_q  <= rptr_q + PtrW'(pop);
      count_q <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (lane_acc[i]) mem[lane_idx[i]] <= push_rec[i];
    end
  end

endmodule

// File: rtl/commit_trace_unit.sv
// Commit trace unit: queues retired instructions, keeps performance counters and
// requests simulation end on a fatal error or a commit watchdog timeout.
module commit_trace_unit
  import commit_trace_unit_pkg::*;
#(
  parameter int unsigned WAYS    = 3,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WAYS-1:0]            commit_valid,
  input  logic [WAYS-1:0][XLEN-1:0]  commit_pc,
  input  logic [WAYS-1:0][4:0]       commit_arn,
  input  logic [WAYS-1:0][XLEN-1:0]  commit_data,
  input  exception_code_t            error_status,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [XLEN-1:0]            trace_pc,
  output logic [4:0]                 trace_arn,
  output logic [XLEN-1:0]            trace_data,
  output logic [63:0]                cycle_count,
  output logic [63:0]                instr_count,
  output logic [31:0]                drop_count,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       halted,
  output halt_cause_t                halt_cause
);

  localparam int unsigned CntW  = $clog2(DEPTH+1);
  localparam int unsigned IdleW = $clog2(TIMEOUT+1);
  localparam int unsigned LaneW = $clog2(WAYS+1);

  state_t          state_q;
  logic [IdleW-1:0] idle_q;
  logic [CntW-1:0] count_next, drop_n;
  trace_rec_t      push_rec [WAYS];
  trace_rec_t      head;
  logic [LaneW-1:0] n_valid;
  logic            any_commit, wd_trig, err_trig;
  logic [32:0]     drop_sum;

  for (genvar i = 0; i < WAYS; i++) begin : g_rec
    assign push_rec[i] = '{pc: commit_pc[i], arn: commit_arn[i], data: commit_data[i]};
  end

  trace_fifo #(
    .WAYS (WAYS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_en   (state_q == StRun),
    .push_valid(commit_valid),
    .push_rec  (push_rec),
    .pop_req   (trace_ready && (state_q != StHalted)),
    .head      (head),
    .count     (fifo_count),
    .count_next(count_next),
    .drop_n    (drop_n)
  );

  assign trace_valid = (fifo_count != '0);
  assign trace_pc    = head.pc;
  assign trace_arn   = head.arn;
  assign trace_data  = head.data;

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < WAYS; i++) n_valid = n_valid + LaneW'(commit_valid[i]);
  end

  assign any_commit = |commit_valid;
  assign wd_trig    = !any_commit && (idle_q == IdleW'(TIMEOUT - 1));
  assign err_trig   = is_fatal_error(error_status);
  assign drop_sum   = {1'b0, drop_count} + 33'(drop_n);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StRun;
      cycle_count <= '0;
      instr_count <= '0;
      drop_count  <= '0;
      idle_q      <= '0;
      halted      <= 1'b0;
      halt_cause  <= HaltNone;
    end else begin
      unique case (state_q)
        StRun: begin
          cycle_count <= cycle_count + 64'd1;
          instr_count <= instr_count + 64'(n_valid);
          drop_count  <= drop_sum[32] ? '1 : drop_sum[31:0];
          idle_q      <= any_commit ? '0 : idle_q + IdleW'(1);
          // Triggering-cycle commits are still pushed; skip DRAIN if nothing is left.
          if (err_trig || wd_trig) begin
            halt_cause <= err_trig ? HaltError : HaltWatchdog;
            if (count_next == '0) begin
              state_q <= StHalted;
              halted  <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (count_next == '0) begin
            state_q <= StHalted;
            halted  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_unit.sv
// Randomised scoreboard bench for commit_trace_unit against a queue-based reference model.
module tb_commit_trace_unit;
  import commit_trace_unit_pkg::*;

  localparam int unsigned WAYS    = 3;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CntW    = $clog2(DEPTH+1);

  logic                      clock = 1'b0;
  logic                      reset;
  logic [WAYS-1:0]           commit_valid;
  logic [WAYS-1:0][XLEN-1:0] commit_pc, commit_data;
  logic [WAYS-1:0][4:0]      commit_arn;
  exception_code_t           error_status;
  logic                      trace_ready;
  logic                      trace_valid;
  logic [XLEN-1:0]           trace_pc, trace_data;
  logic [4:0]                trace_arn;
  logic [63:0]               cycle_count, instr_count;
  logic [31:0]               drop_count;
  logic [CntW-1:0]           fifo_count;
  logic                      halted;
  halt_cause_t               halt_cause;

  commit_trace_unit #(
    .WAYS   (WAYS),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .commit_valid(commit_valid),
    .commit_pc   (commit_pc),
    .commit_arn  (commit_arn),
    .commit_data (commit_data),
    .error_status(error_status),
    .trace_ready (trace_ready),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_arn   (trace_arn),
    .trace_data  (trace_data),
    .cycle_count (cycle_count),
    .instr_count (instr_count),
    .drop_count  (drop_count),
    .fifo_count  (fifo_count),
    .halted      (halted),
    .halt_cause  (halt_cause)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: occupancy, counters and mode, plus the expected record stream.
  trace_rec_t      sb [$];
  trace_rec_t      mon_exp;
  int              m_count, m_idle;
  longint unsigned m_cyc, m_ins, m_drop;
  state_t          m_state;
  halt_cause_t     m_cause;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int free, acc;
    bit pop, er, wd;
    if (reset) begin
      sb.delete();
      m_count = 0; m_idle = 0; m_cyc = 0; m_ins = 0; m_drop = 0;
      m_state = StRun; m_cause = HaltNone;
      return;
    end
    pop = trace_ready && (m_count > 0) && (m_state != StHalted);
    if (m_state == StRun) begin
      free = DEPTH - m_count;
      acc  = 0;
      for (int i = 0; i < WAYS; i++) begin
        if (commit_valid[i]) begin
          m_ins++;
          if (acc < free) begin
            sb.push_back('{pc: commit_pc[i], arn: commit_arn[i], data: commit_data[i]});
            acc++;
          end else if (m_drop < 64'hFFFF_FFFF) begin
            m_drop++;
          end
        end
      end
      m_cyc++;
      er = (error_status != NO_ERROR) && (error_status != LOAD_ACCESS_FAULT);
      wd = (commit_valid == '0) && (m_idle == TIMEOUT - 1);
      m_idle  = (commit_valid != '0) ? 0 : m_idle + 1;
      m_count = m_count + acc - int'(pop);
      if (er || wd) begin
        m_cause = er ? HaltError : HaltWatchdog;
        m_state = (m_count == 0) ? StHalted : StDrain;
      end
    end else if (m_state == StDrain) begin
      m_count = m_count - int'(pop);
      if (m_count == 0) m_state = StHalted;
    end
  endtask

  task automatic check_outputs();
    chk("fifo_count", 64'(fifo_count), 64'(m_count));
    chk("trace_valid", 64'(trace_valid), 64'(m_count != 0));
    chk("cycle_count", cycle_count, m_cyc);
    chk("instr_count", instr_count, m_ins);
    chk("drop_count", 64'(drop_count), m_drop);
    chk("halted", 64'(halted), 64'(m_state == StHalted));
    chk("halt_cause", 64'(halt_cause), 64'(m_cause));
  endtask

  task automatic cyc(input logic rst, input logic [WAYS-1:0] v, input logic rdy,
                     input exception_code_t e);
    reset        = rst;
    commit_valid = v;
    trace_ready  = rdy;
    error_status = e;
    for (int i = 0; i < WAYS; i++) begin
      commit_pc[i]   = XLEN'($urandom);
      commit_arn[i]  = 5'($urandom);
      commit_data[i] = XLEN'($urandom);
    end
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  // Monitor: every head the DUT hands over must match the next expected record.
  always @(negedge clock) begin
    if (!reset && trace_valid && trace_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL head_unexpected: got pc %0h, expected no record", trace_pc);
      end else begin
        mon_exp = sb.pop_front();
        chk("head_pc", 64'(trace_pc), 64'(mon_exp.pc));
        chk("head_arn", 64'(trace_arn), 64'(mon_exp.arn));
        chk("head_data", 64'(trace_data), 64'(mon_exp.data));
      end
    end
  end

  initial begin
    logic [WAYS-1:0] v;
    logic            rdy, rst;
    exception_code_t e;

    reset = 1'b1; commit_valid = '0; trace_ready = 1'b0; error_status = NO_ERROR;
    commit_pc = '0; commit_arn = '0; commit_data = '0;
    cyc(1, 3'b000, 0, NO_ERROR);
    cyc(1, 3'b000, 0, NO_ERROR);

    // Lane compaction: lanes 0 and 2.
    cyc(0, 3'b101, 1, NO_ERROR);
    repeat (3) cyc(0, 3'b000, 1, NO_ERROR);

    // Overflow: 6 offered, 4 fit.
    cyc(0, 3'b111, 0, NO_ERROR);
    cyc(0, 3'b111, 0, NO_ERROR);
    repeat (5) cyc(0, 3'b000, 1, NO_ERROR);

    // Error halt with three queued records draining slowly; later errors ignored.
    cyc(0, 3'b111, 0, NO_ERROR);
    cyc(0, 3'b000, 0, ILLEGAL_INST);
    repeat (4) cyc(0, 3'b000, 0, NO_ERROR);
    repeat (5) cyc(0, 3'b000, 1, NO_ERROR);
    repeat (3) cyc(0, 3'b111, 1, STORE_ACCESS_FAULT);

    // Watchdog from an idle reset.
    cyc(1, 3'b000, 0, NO_ERROR);
    repeat (10) cyc(0, 3'b000, 1, NO_ERROR);

    // Load access faults never halt.
    cyc(1, 3'b000, 0, NO_ERROR);
    for (int i = 0; i < 20; i++) begin
      v = WAYS'($urandom_range(1, 7));
      cyc(0, v, 1'($urandom), LOAD_ACCESS_FAULT);
    end

    // Reset while draining two records.
    cyc(1, 3'b000, 0, NO_ERROR);
    cyc(0, 3'b011, 0, NO_ERROR);
    cyc(0, 3'b000, 0, ILLEGAL_INST);
    cyc(1, 3'b000, 0, NO_ERROR);
    cyc(0, 3'b000, 0, NO_ERROR);

    // Random traffic; odd blocks are sparse enough to let the watchdog fire.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 80; i++) begin
        rst = (m_state == StHalted) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
        if ((b % 2) == 1) v = ($urandom_range(0, 9) == 0) ? WAYS'($urandom) : '0;
        else v = ($urandom_range(0, 3) == 0) ? '0 : WAYS'($urandom);
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 59) == 0) e = ($urandom_range(0, 1) == 0) ? ILLEGAL_INST : ECALL;
        else e = ($urandom_range(0, 5) == 0) ? LOAD_ACCESS_FAULT : NO_ERROR;
        cyc(rst, v, rdy, e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/commit_trace_unit.md
COMMIT_TRACE_UNIT -- requirements
Module: commit_trace_unit

Interface
REQ-001 SHALL have parameter WAYS, default 3, number of commit lanes.
REQ-002 SHALL have parameter DEPTH, default 16, trace FIFO entries, power of two and >= WAYS.
REQ-003 SHALL have parameter TIMEOUT, default 50000, number of consecutive commit-less cycles before a watchdog halt.
REQ-004 SHALL have port clock, input, 1, the clock; reset is synchronous, active-high, on port reset, input, 1.
REQ-005 SHALL have port commit_valid, input, WAYS, per-lane retire valid; lane 0 is the oldest.
REQ-006 SHALL have port commit_pc, input, WAYS x XLEN, PC of each retiring instruction.
REQ-007 SHALL have port commit_arn, input, WAYS x 5, architectural destination register of each lane.
REQ-008 SHALL have port commit_data, input, WAYS x XLEN, writeback value of each lane.
REQ-009 SHALL have port error_status, input, EXCEPTION_CODE, core error status.
REQ-010 SHALL have port trace_ready, input, 1, consumer accepts the head record.
REQ-011 SHALL have port trace_valid, output, 1, head record present.
REQ-012 SHALL have ports trace_pc (XLEN), trace_arn (5) and trace_data (XLEN), all outputs, carrying the head record fields.
REQ-013 SHALL have ports cycle_count and instr_count, outputs, 64 bits each, the performance counters.
REQ-014 SHALL have port drop_count, output, 32, number of commit records lost to a full FIFO.
REQ-015 SHALL have port fifo_count, output, $clog2(DEPTH+1), current FIFO occupancy.
REQ-016 SHALL have port halted, output, 1, simulation end request.
REQ-017 SHALL have port halt_cause, output, HALT_CAUSE, one of NONE, ERROR or WATCHDOG.

Function
REQ-018 SHALL implement states RUN, DRAIN and HALTED, and SHALL leave reset in RUN.
REQ-019 In RUN, each cycle SHALL push the valid lanes into the FIFO in ascending lane order, compacting away invalid lanes.
REQ-020 Free space SHALL be computed as DEPTH - fifo_count, with no credit given for a pop in the same cycle.
REQ-021 When free space is smaller than the valid-lane count, SHALL push the lowest-order lanes that fit, drop the rest, and add the dropped count to drop_count (saturating at 2^32-1).
REQ-022 Pop SHALL occur on trace_valid && trace_ready; trace_valid SHALL equal (fifo_count != 0); a push and a pop in the same cycle SHALL both take effect.
REQ-023 Head fields SHALL be driven from FIFO storage, with no output register, so that a record pushed at edge N is visible after edge N.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 In RUN, cycle_count SHALL increment by 1 per cycle and instr_count SHALL increment by popcount(commit_valid), including dropped records; both SHALL wrap at 2^64.
REQ-026 The idle counter SHALL clear on any commit and otherwise increment each RUN cycle.
REQ-027 A watchdog halt SHALL trigger when the idle counter equals TIMEOUT-1 in a cycle with no commit.
REQ-028 An error halt SHALL trigger when error_status is neither NO_ERROR nor LOAD_ACCESS_FAULT.
REQ-029 If both halt conditions hold in the same cycle, halt_cause SHALL be ERROR.
REQ-030 On a halt trigger, commits in the triggering cycle SHALL be accepted and counted; the state SHALL then go to DRAIN and halt_cause SHALL be latched.
REQ-031 In DRAIN, pushes, counters and the watchdog SHALL freeze while pops continue; the state SHALL go to HALTED on the edge at which the FIFO becomes empty, or immediately if it is already empty.
REQ-032 In HALTED, halted SHALL be 1 and all state SHALL hold until reset; later error_status changes SHALL be ignored.

Reset
REQ-033 Reset SHALL set state RUN, pointers, fifo_count, cycle_count, instr_count, drop_count and the idle counter to 0, halted to 0 and halt_cause to NONE.
REQ-034 Reset mid-DRAIN or in HALTED SHALL discard FIFO contents; trace_valid SHALL be 0 in the first cycle after reset.

Structure
REQ-035 The package SHALL define HALT_CAUSE (NONE, ERROR, WATCHDOG), the trace record struct {pc, arn, data}, and the state enum; EXCEPTION_CODE and XLEN SHALL come from the existing shared definitions.
REQ-036 The FIFO SHALL be a sub-module named trace_fifo, with WAYS-wide compacting push and single pop, parameterised by WAYS and DEPTH.

Verification
REQ-037 Scenario: WAYS=3, DEPTH=4; commit_valid=3'b101 with trace_ready=1 -> two records in lane order 0 then 2, instr_count=2.
REQ-038 Scenario: DEPTH=4, trace_ready=0, two cycles of 3'b111 -> fifo_count=4, drop_count=2, instr_count=6, and the FIFO holds cycle-1 lanes 0-2 then cycle-2 lane 0.
REQ-039 Scenario: TIMEOUT=8, no commits after reset -> halt_cause=WATCHDOG and halted=1 after edge 8, with cycle_count=8.
REQ-040 Scenario: 3 records queued, error_status=ILLEGAL_INST, trace_ready=0 for 5 cycles then 1 -> halted stays 0 until the third pop, then halted=1 with halt_cause=ERROR; counters stay frozen throughout.
REQ-041 Scenario: error_status=LOAD_ACCESS_FAULT for 20 cycles with commits -> no halt, and counters keep advancing.
REQ-042 Scenario: reset asserted in DRAIN with 2 records queued -> next cycle fifo_count=0, trace_valid=0 and state RUN.
